instr_fetch_stage: RTL
======================

// Module: instr_fetch_stage
// PURPOSE
//  - IF stage of the 5-stage RV32 pipeline: owns the PC, fetches from instruction memory over a
//    req/gnt/rvalid handshake, and presents {pc, instr, valid} to the IF/ID pipeline register.
//  - Honours hazard-unit stall (if_id_write) and EX-stage redirects (branch/jump).
//  - Drives if_id_flush to IF/ID on redirect. One outstanding imem request max.
// PARAMETERS
//  - RESET_PC  32'h0000_0000  PC loaded on reset
//  - NOP_INSTR 32'h0000_0013  instr driven when fetch_valid=0 (addi x0,x0,0)
// PORTS
//  - clock           in   1   clock, all state updates on posedge
//  - reset           in   1   synchronous, active-high
//  - if_id_write     in   1   IF/ID load enable from hazard unit; 1 = current output consumed
//  - redirect_valid  in   1   EX-stage taken branch/jump
//  - redirect_pc     in   32  redirect target
//  - imem_req        out  1   fetch request
//  - imem_addr       out  32  fetch address (= pc, bits[1:0]=0)
//  - imem_gnt        in   1   request accepted this cycle (req&gnt)
//  - imem_rvalid     in   1   response valid, >=1 cycle after gnt, in order
//  - imem_rdata      in   32  response instruction
//  - fetch_valid     out  1   fetch_pc/fetch_instr hold a real instruction
//  - fetch_pc        out  32  PC of presented instruction
//  - fetch_instr     out  32  presented instruction (NOP_INSTR when !fetch_valid)
//  - if_id_flush     out  1   = redirect_valid (combinational), clears IF/ID
// BEHAVIOUR
//  - Reset: pc=RESET_PC, state=IDLE, fetch_valid=0, fetch_pc=0, fetch_instr=NOP_INSTR,
//    imem_req=0. Reset mid-transaction abandons it; any later rvalid for it is ignored in IDLE/REQ.
//  - FSM states: IDLE, REQ, WAIT, HOLD, DRAIN. Priority each cycle: reset > redirect > normal.
//  - IDLE: -> REQ next cycle.
//  - REQ: imem_req=1, imem_addr=pc. gnt -> WAIT; else stay (addr may change while ungranted).
//  - WAIT: rvalid -> capture rdata into fetch_instr, fetch_pc<=pc, fetch_valid<=1, -> HOLD.
//  - HOLD: outputs stable while if_id_write=0. if_id_write=1: pc<=pc+4 (wraps mod 2^32),
//    fetch_valid<=0, fetch_instr<=NOP_INSTR, -> REQ.
//  - Redirect (any state): pc<={redirect_pc[31:2],2'b00}; fetch_valid<=0, fetch_instr<=NOP_INSTR.
//    From IDLE/REQ-without-gnt/HOLD -> REQ. From WAIT, or REQ with gnt same cycle -> DRAIN
//    (unless rvalid also high in WAIT: response discarded, -> REQ).
//  - DRAIN: imem_req=0; discard response on rvalid, -> REQ. Redirect in DRAIN updates pc only.
//  - Redirect and if_id_write both high in HOLD: redirect wins, no pc+4.
//  - Latency: min 3 cycles REQ->HOLD with gnt same cycle, rvalid next; redirect target request
//    issued the cycle after redirect (or after drain).
//  - if_id_write=0 outside HOLD has no effect (bubble already presented).
// CONFIGURATION
//  - IF_PERF_CNT_EN defined: adds out ports perf_fetched[31:0] (+1 per HOLD&if_id_write&!redirect)
//    and perf_stall_cycles[31:0] (+1 per HOLD&!if_id_write); both 0 on reset, wrap at 2^32.
//  - Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Reset, gnt same cycle, rvalid +1, rdata=32'h0050_0093, if_id_write=1 -> fetch_valid in 3rd
//    cycle with pc=0, next imem_addr=4.
//  - HOLD with if_id_write=0 for 5 cycles -> outputs unchanged, imem_req=0, pc unchanged.
//  - WAIT, redirect_pc=32'h100 -> if_id_flush=1 that cycle, DRAIN, late rvalid discarded
//    (fetch_valid stays 0), next request addr=32'h100.
//  - HOLD, redirect_valid & if_id_write, redirect_pc=32'h203 -> next addr=32'h200, no pc+4.
//  - pc=32'hFFFF_FFFC consumed -> next imem_addr=0.
//  - IF_PERF_CNT_EN: 4 fetches + 3 stall cycles -> perf_fetched=4, perf_stall_cycles=3;
//    reset mid-WAIT -> counters 0, state IDLE.

Source files
------------

// File: rtl/instr_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_stage
// Description : IF stage of the 5-stage RV32 pipeline. Owns the PC and fetches
//               from instruction memory over a req/gnt/rvalid handshake with at
//               most one request in flight. It presents {pc, instr, valid} to
//               the IF/ID register, honours hazard stalls (if_id_write) and
//               EX-stage redirects, and flushes IF/ID on redirect.
//               Optional macro IF_PERF_CNT_EN adds the perf_fetched and
//               perf_stall_cycles counter ports.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        if_id_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instr,
`ifdef IF_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall_cycles,
`endif
    output logic        if_id_flush
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_DRAIN = 3'd4
    } state_t;

    localparam logic [31:0] C_PC_STEP = 32'd4;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        fetch_valid_q, fetch_valid_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fetch_instr_q, fetch_instr_d;
    logic        imem_req_q, imem_req_d;

    // Redirect targets are word aligned; the two low target bits are dropped.
    logic        unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Next-state logic: normal flow first, then a redirect overrides it.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fetch_valid_d = fetch_valid_q;
        fetch_pc_d    = fetch_pc_q;
        fetch_instr_d = fetch_instr_q;

        case (state_q)
            S_IDLE:  state_d = S_REQ;
            S_REQ:   if (imem_gnt) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    fetch_instr_d = imem_rdata;
                    fetch_pc_d    = pc_q;
                    fetch_valid_d = 1'b1;
                    state_d       = S_HOLD;
                end
            end
            S_HOLD: begin
                if (if_id_write) begin
                    pc_d          = pc_q + C_PC_STEP;
                    fetch_valid_d = 1'b0;
                    fetch_instr_d = NOP_INSTR;
                    state_d       = S_REQ;
                end
            end
            S_DRAIN: if (imem_rvalid) state_d = S_REQ;
            default: state_d = S_IDLE;
        endcase

        if (redirect_valid) begin
            pc_d          = {redirect_pc[31:2], 2'b00};
            fetch_valid_d = 1'b0;
            fetch_instr_d = NOP_INSTR;
            fetch_pc_d    = fetch_pc_q;
            case (state_q)
                // A request accepted this cycle still owes a response to drain.
                S_REQ:   state_d = imem_gnt ? S_DRAIN : S_REQ;
                S_WAIT:  state_d = imem_rvalid ? S_REQ : S_DRAIN;
                S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default: state_d = S_REQ;
            endcase
        end

        imem_req_d = (state_d == S_REQ);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= {RESET_PC[31:2], 2'b00};
            fetch_valid_q <= 1'b0;
            fetch_pc_q    <= 32'd0;
            fetch_instr_q <= NOP_INSTR;
            imem_req_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            fetch_pc_q    <= fetch_pc_d;
            fetch_instr_q <= fetch_instr_d;
            imem_req_q    <= imem_req_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = pc_q;
    assign fetch_valid = fetch_valid_q;
    assign fetch_pc    = fetch_pc_q;
    assign fetch_instr = fetch_instr_q;
    assign if_id_flush = redirect_valid;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_stall_q, perf_stall_d;

    // Count consumed instructions and stalled presentation cycles.
    always_comb begin
        perf_fetched_d = perf_fetched_q;
        perf_stall_d   = perf_stall_q;
        if (state_q == S_HOLD) begin
            if (if_id_write && !redirect_valid) perf_fetched_d = perf_fetched_q + 32'd1;
            if (!if_id_write)                   perf_stall_d   = perf_stall_q + 32'd1;
        end
    end

    // Counter registers, cleared on reset and wrapping naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched_q <= 32'd0;
            perf_stall_q   <= 32'd0;
        end else begin
            perf_fetched_q <= perf_fetched_d;
            perf_stall_q   <= perf_stall_d;
        end
    end

    assign perf_fetched      = perf_fetched_q;
    assign perf_stall_cycles = perf_stall_q;
`endif

endmodule
`default_nettype wire
